// File: rtl/uart_rx_fsm_pkg.sv
// ============================================================================
// uart_rx_fsm_pkg : shared UART RX state encodings and prescale-derived edges
// Revision 1.0
// ============================================================================
`default_nettype none

package uart_rx_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Any ratio other than 16 or 32 falls back to 8x oversampling.
  function automatic logic [4:0] last_edge(input logic [5:0] p);
    case (p)
      PRESCALE_16: return 5'd15;
      PRESCALE_32: return 5'd31;
      default:     return 5'd7;
    endcase
  endfunction

  function automatic logic [4:0] sample_edge(input logic [5:0] p);
    case (p)
      PRESCALE_16: return 5'd10;
      PRESCALE_32: return 5'd18;
      default:     return 5'd6;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_edge_bit_counter.sv
// ============================================================================
// uart_rx_edge_bit_counter : oversample edge counter and bit counter
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_edge_bit_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [4:0] last_edge,
  output logic [4:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       bit_end
);

  assign bit_end = (edge_cnt == last_edge);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= 5'd0;
      bit_cnt  <= 4'd0;
    end else if (en) begin
      if (bit_end) begin
        edge_cnt <= 5'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fsm.sv
// ============================================================================
// uart_rx_fsm : UART receive frame sequencer driving the RX datapath enables
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [4:0]                edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      deser_en,
  output logic                      data_valid
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] s_edge;
  logic [4:0] l_edge;
  logic       err;
  logic       bit_end;

  uart_rx_edge_bit_counter u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .en       (state != ST_IDLE),
    .clr      (state_nxt == ST_IDLE),
    .last_edge(l_edge),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = strt_glitch ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && bit_cnt == LAST_DATA_BIT)
                   state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Enables are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      deser_en    <= 1'b0;
      err         <= 1'b0;
      s_edge      <= sample_edge(PRESCALE_8);
      l_edge      <= last_edge(PRESCALE_8);
    end else begin
      state       <= state_nxt;
      dat_samp_en <= (state_nxt != ST_IDLE);
      strt_chk_en <= (state_nxt == ST_START);
      par_chk_en  <= (state_nxt == ST_PARITY);
      stp_chk_en  <= (state_nxt == ST_STOP);
      deser_en    <= (state == ST_DATA) && (edge_cnt == s_edge);
      if (state == ST_IDLE && state_nxt == ST_START) begin
        s_edge <= sample_edge(prescale);
        l_edge <= last_edge(prescale);
        err    <= 1'b0;
      end
      if (state == ST_PARITY && bit_end) err <= par_err;
    end
  end

  // Stop checker result is only settled on the last edge, so validity is decoded there.
  assign data_valid = !RST && (state == ST_STOP) && bit_end && !stp_err && !err;

endmodule

`default_nettype wire
